field_addsub_vec: RTL and testbench
===================================

// Module: field_addsub_vec
// PURPOSE
//  Parametrised, synthesisable successor to the scalar field adder.
//  Performs NLANES independent mod-p add / sub / negate operations in lock-step on one
//  shared start/ready handshake, with a programmable latency N_CYC.
//  Sits beside the field multipliers in gate/layer compute units; no VPI dependency.
// PARAMETERS
//  NLANES    4          number of parallel lanes, >=1
//  N_CYC     2          en-to-result latency in cycles, >=2 (stage1 add, stage2 reduce, rest delay)
//  DFL_OUT   0          value every lane of c takes at reset
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 asynchronous, active-high reset
//  en           in   1                 start; sampled only while ready=1
//  op           in   2                 field_addsub_pkg::op_t: ADD=0, SUB=1, NEG=2, PASS=3
//  a            in   NLANES*F_NBITS    operand A, lane i at [i*F_NBITS +: F_NBITS]
//  b            in   NLANES*F_NBITS    operand B, ignored for NEG and PASS
//  ready_pulse  out  1                 one-cycle strobe: c just updated
//  ready        out  1                 idle, will accept en
//  c            out  NLANES*F_NBITS    result, held until the next completion
// BEHAVIOUR
//  Reset (async, rst=1): ready=1, ready_pulse=0, every lane of c=DFL_OUT,
//    latency counter=0, pipeline registers cleared.
//  FSM: IDLE -> BUSY on en&&ready at edge T; operands and op captured at T.
//    ready=0 during cycles T+1 .. T+N_CYC-1.
//    At edge T+N_CYC: c updated, ready_pulse=1 for that cycle only, ready=1, back to IDLE.
//    en in the same cycle as ready_pulse (ready=1) starts the next op: back-to-back
//      throughput is one op per N_CYC cycles.
//  en while ready=0: ignored, with no effect on the operation in flight.
//  Arithmetic per lane; operands are required < p (`F_Q); widths are F_NBITS, internal F_NBITS+1:
//    ADD : s=a+b;  c = (s>=p) ? s-p : s
//    SUB : c = (a>=b) ? a-b : a-b+p   (borrow detected from bit F_NBITS)
//    NEG : c = (a==0) ? 0 : p-a
//    PASS: c = a
//  Boundaries:
//    a=b=p-1 ADD -> p-2.  a=0,b=0 SUB -> 0.  NEG of 0 -> 0, never p.
//  Reset mid-operation: operation abandoned, no ready_pulse, reset values restored.
//  Lanes are fully independent; no carry or interaction across lane boundaries.
// CONFIGURATION
//  FIELD_ADDSUB_RANGECHK_EN defined:
//    extra output port range_err (1 bit, reset 0).
//    At capture, any lane with a>=p, or b>=p (ADD/SUB only), sets range_err.
//    range_err is valid together with ready_pulse for that op and stays high until
//      the next accepted en or reset.
//    Results are computed as usual and are undefined for offending lanes.
//  Not defined: no range_err port, no compare logic; out-of-range input gives an
//    undefined c.
// STRUCTURE
//  Package field_addsub_pkg:
//    op_t enum (ADD, SUB, NEG, PASS)
//    localparam P = `F_Q
//    lane width = `F_NBITS
//  Sub-module field_addsub_lane:
//    one lane
//    stage1 registers the raw sum/difference plus borrow/overflow flag
//    stage2 is combinational reduction, registered in the top-level result register
//    instantiated with generate-for over NLANES
//  Top level owns the FSM, the $clog2(N_CYC) latency counter, the delay/output
//    registers and the handshake.
// TESTING  (bench build: F_NBITS=7, F_Q=97, NLANES=4, N_CYC=3)
//  1. Reset, then idle: ready=1, ready_pulse=0, c=0 on every lane; assert rst mid-op
//     -> no pulse, c=0.
//  2. en, ADD, a={96,50,0,1}, b={96,47,0,95} -> exactly 3 cycles later
//     c={95,0,0,96}, ready_pulse=1 for one cycle.
//  3. SUB, a={0,5,96,10}, b={1,5,0,20} -> c={96,0,96,87};
//     NEG, a={0,1,96,48} -> c={0,96,1,49}.
//  4. en pulsed on cycles T+1 and T+2 while busy -> ignored, c from the T op only;
//     en on the pulse cycle -> second result at T+6.
//  5. PASS, a={7,8,9,10}, b=random -> c={7,8,9,10}; c holds unchanged over 20 idle cycles.
//  6. RANGECHK_EN build: ADD with a lane-2 a=100 -> range_err=1 at ready_pulse;
//     next valid op clears it.

Source files
------------

// File: rtl/field_addsub_pkg.sv
// Shared types and constants for the vector mod-p adder/subtractor.
// Field width and modulus come from `F_NBITS / `F_Q.
`ifndef F_NBITS
`define F_NBITS 7
`endif
`ifndef F_Q
`define F_Q 97
`endif

package field_addsub_pkg;

  localparam int unsigned LANE_W = `F_NBITS;
  localparam logic [LANE_W-1:0] P = LANE_W'(`F_Q);

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    PASS = 2'd3
  } op_t;

  typedef logic [LANE_W-1:0] elem_t;

endpackage

// File: rtl/field_addsub_lane.sv
// One mod-p lane: stage1 registers the raw sum/difference and its correction flag,
// stage2 is the combinational reduction sampled by the top-level result register.
module field_addsub_lane
  import field_addsub_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  op_t   op,
  input  elem_t a,
  input  elem_t b,
  output elem_t res
);

  logic [LANE_W:0] a_x, b_x, p_x, sum, dif;
  logic [LANE_W:0] raw;
  logic            flag;
  op_t             op_q;

  always_comb begin
    a_x = {1'b0, a};
    b_x = {1'b0, b};
    p_x = {1'b0, P};
    sum = a_x + b_x;
    dif = a_x - b_x;
  end

  // flag means: ADD overflowed p, SUB borrowed, NEG operand was zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw  <= '0;
      flag <= 1'b0;
      op_q <= ADD;
    end else if (load) begin
      op_q <= op;
      case (op)
        ADD: begin
          raw  <= sum;
          flag <= (sum >= p_x);
        end
        SUB: begin
          raw  <= dif;
          flag <= dif[LANE_W];
        end
        NEG: begin
          raw  <= p_x - a_x;
          flag <= (a == '0);
        end
        default: begin
          raw  <= a_x;
          flag <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    res = raw[LANE_W-1:0];
    case (op_q)
      ADD:     if (flag) res = LANE_W'(raw - p_x);
      SUB:     if (flag) res = LANE_W'(raw + p_x);
      NEG:     if (flag) res = '0;
      default: res = raw[LANE_W-1:0];
    endcase
  end

endmodule

// File: rtl/field_addsub_vec.sv
// NLANES-wide mod-p add/sub/negate/pass with a shared start/ready handshake and
// N_CYC-cycle latency. Optional range check enabled by FIELD_ADDSUB_RANGECHK_EN.
module field_addsub_vec
  import field_addsub_pkg::*;
#(
  parameter int unsigned NLANES  = 4,
  parameter int unsigned N_CYC   = 2,
  parameter int unsigned DFL_OUT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  op_t                        op,
  input  logic [NLANES*LANE_W-1:0]   a,
  input  logic [NLANES*LANE_W-1:0]   b,
  output logic                       ready_pulse,
  output logic                       ready,
  output logic [NLANES*LANE_W-1:0]   c
`ifdef FIELD_ADDSUB_RANGECHK_EN
  ,
  output logic                       range_err
`endif
);

  localparam int unsigned CW = (N_CYC > 1) ? $clog2(N_CYC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic                       accept, done;
  logic [NLANES*LANE_W-1:0]   res;

  assign accept = en && ready;
  assign done   = (state == BUSY) && (cnt == CW'(N_CYC - 1));

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    field_addsub_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .op   (op),
      .a    (a[i*LANE_W +: LANE_W]),
      .b    (b[i*LANE_W +: LANE_W]),
      .res  (res[i*LANE_W +: LANE_W])
    );
  end

  // ready rises in the last busy cycle so an en there is captured on the same edge
  // that retires the current op, giving one op per N_CYC cycles back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ready       <= 1'b1;
      ready_pulse <= 1'b0;
      c           <= {NLANES{LANE_W'(DFL_OUT)}};
    end else begin
      ready_pulse <= done;
      if (done) c <= res;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        BUSY: begin
          if (done) begin
            cnt <= '0;
            if (accept) ready <= 1'b0;
            else        state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(N_CYC - 2)) ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIELD_ADDSUB_RANGECHK_EN
  logic [NLANES-1:0] lane_bad;
  logic              range_pend;

  always_comb begin
    lane_bad = '0;
    for (int unsigned i = 0; i < NLANES; i++)
      lane_bad[i] = (a[i*LANE_W +: LANE_W] >= P) ||
                    (((op == ADD) || (op == SUB)) && (b[i*LANE_W +: LANE_W] >= P));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_pend <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      if (accept) range_pend <= |lane_bad;
      if (done)        range_err <= range_pend;
      else if (accept) range_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_field_addsub_vec.sv
// Self-checking bench for field_addsub_vec (F_NBITS=7, F_Q=97, NLANES=4, N_CYC=3).
// Covers range_err too when FIELD_ADDSUB_RANGECHK_EN is defined.
module tb_field_addsub_vec;
  import field_addsub_pkg::*;

  localparam int          NL = 4;
  localparam int          NC = 3;
  localparam int unsigned W  = LANE_W;
  localparam int unsigned Q  = 32'(P);

  typedef logic [NL*W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  op_t  op  = ADD;
  vec_t a   = '0;
  vec_t b   = '0;
  vec_t c;
  logic ready, ready_pulse;
`ifdef FIELD_ADDSUB_RANGECHK_EN
  logic range_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  field_addsub_vec #(.NLANES(NL), .N_CYC(NC), .DFL_OUT(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .op          (op),
    .a           (a),
    .b           (b),
    .ready_pulse (ready_pulse),
    .ready       (ready),
    .c           (c)
`ifdef FIELD_ADDSUB_RANGECHK_EN
    ,
    .range_err   (range_err)
`endif
  );

  function automatic int unsigned ref_lane(op_t o, int unsigned x, int unsigned y);
    case (o)
      ADD:     return (x + y) % Q;
      SUB:     return (x + Q - y) % Q;
      NEG:     return (Q - x) % Q;
      default: return x;
    endcase
  endfunction

  function automatic vec_t ref_vec(op_t o, vec_t x, vec_t y);
    vec_t r;
    r = '0;
    for (int i = 0; i < NL; i++)
      r[i*W +: W] = W'(ref_lane(o, 32'(x[i*W +: W]), 32'(y[i*W +: W])));
    return r;
  endfunction

  function automatic vec_t pack4(int unsigned v3, int unsigned v2, int unsigned v1, int unsigned v0);
    return {W'(v3), W'(v2), W'(v1), W'(v0)};
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*W +: W] = W'($urandom_range(Q - 1));
    return r;
  endfunction

  // Drives one start; returns at the falling edge just after the capture edge.
  task automatic issue(input op_t o, input vec_t x, input vec_t y);
    @(negedge clk);
    en = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    en = 1'b0; a = vec_t'($urandom); b = vec_t'($urandom);
  endtask

  // Cycles from capture to the pulse (-1 on timeout) and cycles seen with ready low.
  task automatic wait_pulse(output int lat, output int lows);
    lows = (ready === 1'b0) ? 1 : 0;
    lat  = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (ready_pulse === 1'b1) break;
      if (ready === 1'b0) lows++;
      if (lat >= 20) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1; en = 1'b0; op = ADD; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (c !== '0 || ready !== 1'b1 || ready_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: c=%h ready=%b pulse=%b required c=0 ready=1 pulse=0", c, ready, ready_pulse);
    end
`ifdef FIELD_ADDSUB_RANGECHK_EN
    checks++;
    if (range_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_range_err: got %b required 0", range_err);
    end
`endif
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (c !== '0 || ready !== 1'b1 || ready_pulse !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: c=%h ready=%b pulse=%b required c=0 ready=1 pulse=0", c, ready, ready_pulse);
      end
    end
    issue(ADD, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (c !== '0 || ready !== 1'b1 || ready_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: c=%h ready=%b pulse=%b required c=0 ready=1 pulse=0", c, ready, ready_pulse);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (2*NC + 2) begin
      @(negedge clk);
      if (ready_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || c !== '0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL abandoned_op: pulses=%0d c=%h ready=%b required pulses=0 c=0 ready=1", pulses, c, ready);
    end
  endtask

  task automatic test_add();
    vec_t x, y, exp;
    op_t  o;
    int   lat, lows;
    x = pack4(96, 50, 0, 1);
    y = pack4(96, 47, 0, 95);
    exp = pack4(95, 0, 0, 96);
    issue(ADD, x, y);
    wait_pulse(lat, lows);
    checks++;
    if (lat !== NC) begin
      errors++;
      $display("FAIL add_latency: got %0d required %0d", lat, NC);
    end
    checks++;
    if (lows !== NC - 1) begin
      errors++;
      $display("FAIL ready_low_cycles: got %0d required %0d", lows, NC - 1);
    end
    checks++;
    if (c !== exp) begin
      errors++;
      $display("FAIL add_directed: got %h required %h", c, exp);
    end
    @(negedge clk);
    checks++;
    if (ready_pulse !== 1'b0 || ready !== 1'b1 || c !== exp) begin
      errors++;
      $display("FAIL pulse_width: pulse=%b ready=%b c=%h required pulse=0 ready=1 c=%h", ready_pulse, ready, c, exp);
    end
    repeat (16) begin
      o = op_t'(2'($urandom_range(3)));
      x = rand_vec();
      y = rand_vec();
      exp = ref_vec(o, x, y);
      issue(o, x, y);
      wait_pulse(lat, lows);
      checks++;
      if (lat !== NC || c !== exp) begin
        errors++;
        $display("FAIL random_op %s a=%h b=%h: got c=%h lat=%0d required c=%h lat=%0d", o.name(), x, y, c, lat, exp, NC);
      end
    end
  endtask

  task automatic test_sub_neg();
    vec_t exp;
    int   lat, lows;
    exp = pack4(96, 0, 96, 87);
    issue(SUB, pack4(0, 5, 96, 10), pack4(1, 5, 0, 20));
    wait_pulse(lat, lows);
    checks++;
    if (lat !== NC || c !== exp) begin
      errors++;
      $display("FAIL sub_directed: got c=%h lat=%0d required c=%h lat=%0d", c, lat, exp, NC);
    end
    exp = pack4(0, 96, 1, 49);
    issue(NEG, pack4(0, 1, 96, 48), rand_vec());
    wait_pulse(lat, lows);
    checks++;
    if (lat !== NC || c !== exp) begin
      errors++;
      $display("FAIL neg_directed: got c=%h lat=%0d required c=%h lat=%0d", c, lat, exp, NC);
    end
    exp = pack4(0, 0, 0, 0);
    issue(SUB, pack4(0, 0, 0, 0), pack4(0, 0, 0, 0));
    wait_pulse(lat, lows);
    checks++;
    if (c !== exp) begin
      errors++;
      $display("FAIL sub_zero: got %h required %h", c, exp);
    end
  endtask

  task automatic test_busy_ignore();
    vec_t x, y, exp;
    int   pulses;
    x = pack4(10, 20, 30, 40);
    y = pack4(5, 5, 5, 5);
    exp = pack4(5, 15, 25, 35);
    @(negedge clk);
    en = 1'b1; op = SUB; a = x; b = y;
    @(negedge clk);
    op = ADD; a = rand_vec(); b = rand_vec();
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_pulse !== 1'b1 || c !== exp) begin
      errors++;
      $display("FAIL busy_en_result: pulse=%b c=%h required pulse=1 c=%h", ready_pulse, c, exp);
    end
    pulses = 0;
    repeat (2*NC) begin
      @(negedge clk);
      if (ready_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || c !== exp) begin
      errors++;
      $display("FAIL busy_en_ignored: extra pulses=%0d c=%h required 0 and c=%h", pulses, c, exp);
    end
  endtask

  task automatic test_back_to_back();
    vec_t x, y, exp_cur, exp_next;
    op_t  o;
    int   lat, lows;
    o = op_t'(2'($urandom_range(3)));
    x = rand_vec();
    y = rand_vec();
    exp_cur = ref_vec(o, x, y);
    issue(o, x, y);
    repeat (4) begin
      @(negedge clk);
      @(negedge clk);
      o = op_t'(2'($urandom_range(3)));
      x = rand_vec();
      y = rand_vec();
      exp_next = ref_vec(o, x, y);
      en = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      en = 1'b0;
      checks++;
      if (ready_pulse !== 1'b1 || c !== exp_cur) begin
        errors++;
        $display("FAIL back_to_back: pulse=%b c=%h required pulse=1 c=%h", ready_pulse, c, exp_cur);
      end
      exp_cur = exp_next;
    end
    wait_pulse(lat, lows);
    checks++;
    if (lat !== NC || c !== exp_cur) begin
      errors++;
      $display("FAIL back_to_back_last: got c=%h lat=%0d required c=%h lat=%0d", c, lat, exp_cur, NC);
    end
  endtask

  task automatic test_pass_hold();
    vec_t exp;
    int   lat, lows;
    exp = pack4(7, 8, 9, 10);
    issue(PASS, exp, vec_t'($urandom));
    wait_pulse(lat, lows);
    checks++;
    if (lat !== NC || c !== exp) begin
      errors++;
      $display("FAIL pass: got c=%h lat=%0d required c=%h lat=%0d", c, lat, exp, NC);
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (c !== exp || ready_pulse !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: c=%h pulse=%b required c=%h pulse=0", c, ready_pulse, exp);
      end
    end
  endtask

`ifdef FIELD_ADDSUB_RANGECHK_EN
  task automatic test_range();
    int lat, lows;
    issue(ADD, pack4(1, 100, 2, 3), pack4(1, 1, 1, 1));
    wait_pulse(lat, lows);
    checks++;
    if (lat !== NC || range_err !== 1'b1) begin
      errors++;
      $display("FAIL range_err_set: got %b lat=%0d required 1 lat=%0d", range_err, lat, NC);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (range_err !== 1'b1) begin
      errors++;
      $display("FAIL range_err_hold: got %b required 1", range_err);
    end
    issue(PASS, pack4(1, 2, 3, 4), pack4(120, 120, 120, 120));
    checks++;
    if (range_err !== 1'b0) begin
      errors++;
      $display("FAIL range_err_clear_on_en: got %b required 0", range_err);
    end
    wait_pulse(lat, lows);
    checks++;
    if (range_err !== 1'b0) begin
      errors++;
      $display("FAIL range_err_valid_op: got %b required 0", range_err);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub_neg();
    test_busy_ignore();
    test_back_to_back();
    test_pass_hold();
`ifdef FIELD_ADDSUB_RANGECHK_EN
    test_range();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
